clk_div_gen: RTL

//  Synthesizable multi-channel clock-divider / clock-enable generator that replaces the

---
 rtl/clk_div_pkg.sv | 17 +
 rtl/clk_div_chan.sv | 65 ++++++
 rtl/clk_div_gen.sv | 65 ++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
package clk_div_pkg;

    localparam int CNT_W_DEF     = 8;
    localparam int DIV_RESET_DEF = 8;

    // A divisor of 0 has no meaning, so it behaves as divide-by-1.
    function automatic int unsigned div_norm(input int unsigned v);
        return (v == 0) ? 32'd1 : v;
    endfunction

    // Number of high cycles in one divided period; odd divisors get the extra one.
    function automatic int unsigned ceil_half(input int unsigned d);
        return (d + 32'd1) / 32'd2;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: phase counter, active/shadow divisor and registered outputs.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int DIV_RESET = DIV_RESET_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] val,
    output logic             clk_en,
    output logic             clk_div
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] shadow;
    logic             pend;
    logic [CNT_W-1:0] shadow_nxt;
    logic             pend_nxt;
    logic             wrap;

    // A write in the same cycle as an apply point is folded in before the apply.
    always_comb begin
        shadow_nxt = wr ? CNT_W'(div_norm(32'(val))) : shadow;
        pend_nxt   = pend | wr;
        wrap       = (cnt == div - CNT_W'(1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            div     <= CNT_W'(DIV_RESET);
            shadow  <= CNT_W'(DIV_RESET);
            pend    <= 1'b0;
            clk_en  <= 1'b0;
            clk_div <= 1'b0;
        end else begin
            shadow <= shadow_nxt;
            pend   <= pend_nxt;
            if (!enable) begin
                cnt     <= '0;
                clk_en  <= 1'b0;
                clk_div <= 1'b0;
            end else if (sync || wrap) begin
                // Period boundary: the divisor only ever changes here, so no runt pulses.
                cnt     <= '0;
                clk_en  <= !sync;
                clk_div <= 1'b1;
                if (pend_nxt) begin
                    div  <= shadow_nxt;
                    pend <= 1'b0;
                end
            end else begin
                cnt     <= cnt + CNT_W'(1);
                clk_en  <= 1'b0;
                clk_div <= (32'(cnt) + 32'd1) < ceil_half(32'(div));
            end
        end
    end

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel clock-enable / divided-clock generator with divisor write port and lock flag.
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int NCHAN       = 4,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DIV_RESET   = DIV_RESET_DEF,
    parameter int LOCK_CYCLES = 16,
    parameter int SEL_W       = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sync,
    input  logic             div_wr,
    input  logic [SEL_W-1:0] div_sel,
    input  logic [CNT_W-1:0] div_val,
    output logic             div_ack,
    output logic [NCHAN-1:0] clk_en,
    output logic [NCHAN-1:0] clk_div,
    output logic             locked
);

    localparam int LCW = $clog2(LOCK_CYCLES + 1);

    logic           wr_ok;
    logic [LCW-1:0] lock_cnt;

    assign wr_ok = div_wr && (32'(div_sel) < 32'(NCHAN));

    for (genvar g = 0; g < NCHAN; g++) begin : g_chan
        clk_div_chan #(
            .CNT_W     (CNT_W),
            .DIV_RESET (DIV_RESET)
        ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .enable  (enable),
            .sync    (sync),
            .wr      (wr_ok && (32'(div_sel) == 32'(g))),
            .val     (div_val),
            .clk_en  (clk_en[g]),
            .clk_div (clk_div[g])
        );
    end

    // Lock counter saturates at LOCK_CYCLES; divisor writes never disturb it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_ack  <= 1'b0;
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            div_ack <= wr_ok;
            if (!enable || sync) begin
                lock_cnt <= '0;
                locked   <= 1'b0;
            end else if (lock_cnt != LCW'(LOCK_CYCLES)) begin
                lock_cnt <= lock_cnt + LCW'(1);
                locked   <= (lock_cnt == LCW'(LOCK_CYCLES - 1));
            end
        end
    end

endmodule
